// File: rtl/alu_mul_sequencer.sv
// Multi-cycle unsigned shift-and-add multiplier.
// All arithmetic goes through an external shared ALU; this block only sequences it.

`ifndef ADDITION
`define ADDITION 4'd0
`endif
`ifndef SHIFT_LEFT
`define SHIFT_LEFT 4'd5
`endif
`ifndef SHIFT_RIGHT
`define SHIFT_RIGHT 4'd6
`endif

module alu_mul_sequencer #(
    parameter int BITSIZE = 32
) (
    input  logic               clk,
    input  logic               rst_i,
    input  logic               req_valid_i,
    output logic               req_ready_o,
    input  logic [BITSIZE-1:0] a_i,
    input  logic [BITSIZE-1:0] b_i,
    input  logic               abort_i,
    output logic               resp_valid_o,
    input  logic               resp_ready_i,
    output logic [BITSIZE-1:0] result_o,
    output logic               overflow_o,
    output logic [BITSIZE-1:0] alu_a_o,
    output logic [BITSIZE-1:0] alu_b_o,
    output logic [3:0]         alu_op_o,
    input  logic [BITSIZE-1:0] alu_r_i,
    input  logic               alu_ovf_i
);

    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] ADD  = 3'd1;
    localparam logic [2:0] SHL  = 3'd2;
    localparam logic [2:0] SHR  = 3'd3;
    localparam logic [2:0] DONE = 3'd4;

    logic [2:0]         state;
    logic [BITSIZE-1:0] acc;
    logic [BITSIZE-1:0] mcand;
    logic [BITSIZE-1:0] mplier;
    logic               ovf;

    always_comb begin
        alu_a_o  = '0;
        alu_b_o  = '0;
        alu_op_o = `ADDITION;
        case (state)
            ADD: begin
                alu_a_o  = acc;
                alu_b_o  = mcand;
                alu_op_o = `ADDITION;
            end
            SHL: begin
                alu_a_o  = mcand;
                alu_op_o = `SHIFT_LEFT;
            end
            SHR: begin
                alu_a_o  = mplier;
                alu_op_o = `SHIFT_RIGHT;
            end
            default: ;
        endcase
    end

    assign req_ready_o  = (state == IDLE);
    assign resp_valid_o = (state == DONE);
    assign result_o     = acc;
    assign overflow_o   = ovf;

    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            state  <= IDLE;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            ovf    <= 1'b0;
        end else if (state != IDLE && abort_i) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid_i) begin
                        mcand  <= a_i;
                        mplier <= b_i;
                        acc    <= '0;
                        ovf    <= 1'b0;
                        if (b_i == '0)
                            state <= DONE;
                        else if (b_i[0])
                            state <= ADD;
                        else
                            state <= SHL;
                    end
                end
                ADD: begin
                    acc   <= alu_r_i;
                    ovf   <= ovf | alu_ovf_i;
                    state <= SHL;
                end
                SHL: begin
                    mcand <= alu_r_i;
                    // A dropped multiplicand MSB only matters if a higher multiplier bit would still add it.
                    if (mcand[BITSIZE-1] && ((mplier >> 1) != '0))
                        ovf <= 1'b1;
                    state <= (alu_r_i == '0) ? DONE : SHR;
                end
                SHR: begin
                    mplier <= alu_r_i;
                    if (alu_r_i == '0)
                        state <= DONE;
                    else if (alu_r_i[0])
                        state <= ADD;
                    else
                        state <= SHL;
                end
                DONE: begin
                    if (resp_ready_i)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// Self-checking bench for alu_mul_sequencer at BITSIZE=8 with a behavioural ALU
// and an arithmetic product/latency reference model.

`ifndef ADDITION
`define ADDITION 4'd0
`endif
`ifndef SHIFT_LEFT
`define SHIFT_LEFT 4'd5
`endif
`ifndef SHIFT_RIGHT
`define SHIFT_RIGHT 4'd6
`endif

module tb_alu_mul_sequencer;

    localparam int N = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         req_valid = 1'b0;
    logic         req_ready;
    logic [N-1:0] a = '0;
    logic [N-1:0] b = '0;
    logic         abort = 1'b0;
    logic         resp_valid;
    logic         resp_ready = 1'b0;
    logic [N-1:0] result;
    logic         overflow;
    logic [N-1:0] alu_a;
    logic [N-1:0] alu_b;
    logic [3:0]   alu_op;
    logic [N-1:0] alu_r;
    logic         alu_ovf;

    int assert_count = 0;
    int fail_count = 0;

    alu_mul_sequencer #(.BITSIZE(N)) dut (
        .clk(clk),
        .rst_i(rst),
        .req_valid_i(req_valid),
        .req_ready_o(req_ready),
        .a_i(a),
        .b_i(b),
        .abort_i(abort),
        .resp_valid_o(resp_valid),
        .resp_ready_i(resp_ready),
        .result_o(result),
        .overflow_o(overflow),
        .alu_a_o(alu_a),
        .alu_b_o(alu_b),
        .alu_op_o(alu_op),
        .alu_r_i(alu_r),
        .alu_ovf_i(alu_ovf)
    );

    always #5 clk = ~clk;

    // Behavioural stand-in for the shared ALU: add with carry-out, shift by one.
    always_comb begin
        alu_r   = '0;
        alu_ovf = 1'b0;
        case (alu_op)
            `ADDITION:    {alu_ovf, alu_r} = {1'b0, alu_a} + {1'b0, alu_b};
            `SHIFT_LEFT:  {alu_ovf, alu_r} = {alu_a, 1'b0};
            `SHIFT_RIGHT: alu_r = alu_a >> 1;
            default: ;
        endcase
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assert_count++;
        if (observed !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    // Cycles from accept edge to first resp_valid, from the per-bit cost rules.
    function automatic int model_latency(input int av, input int bv);
        int lat;
        lat = 1;
        if (bv == 0) return lat;
        for (int k = 0; k < N; k++) begin
            if ((bv >> k) & 1) lat++;
            lat++;
            if (((av << (k + 1)) % (1 << N)) == 0) break;
            lat++;
            if ((bv >> (k + 1)) == 0) break;
        end
        return lat;
    endfunction

    task automatic applyStimulus(input int av, input int bv, input int hold_cycles);
        int n;
        int prod;
        prod = av * bv;
        a = N'(av);
        b = N'(bv);
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        n = 1;
        while (!resp_valid && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        checkOutput("latency", n, model_latency(av, bv));
        checkOutput("result", result, prod % (1 << N));
        checkOutput("overflow", overflow, (prod >= (1 << N)) ? 1 : 0);
        repeat (hold_cycles) begin
            @(posedge clk); #1;
            checkOutput("hold_valid", resp_valid, 1);
            checkOutput("hold_result", result, prod % (1 << N));
        end
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        checkOutput("ready_after_resp", req_ready, 1);
        checkOutput("valid_after_resp", resp_valid, 0);
    endtask

    initial begin
        logic [3:0] exp_ops [8];
        exp_ops = '{`ADDITION, `SHIFT_LEFT, `SHIFT_RIGHT, `SHIFT_LEFT, `SHIFT_RIGHT,
                    `ADDITION, `SHIFT_LEFT, `SHIFT_RIGHT};

        rst = 1'b1;
        #12;
        checkOutput("rst_req_ready", req_ready, 1);
        checkOutput("rst_resp_valid", resp_valid, 0);
        checkOutput("rst_result", result, 0);
        checkOutput("rst_overflow", overflow, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // 3x5 with the ALU operation checked every cycle of the walk.
        a = 8'd3; b = 8'd5; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            checkOutput("op_seq", alu_op, exp_ops[i]);
            checkOutput("busy_valid", resp_valid, 0);
            @(posedge clk); #1;
        end
        checkOutput("3x5_valid", resp_valid, 1);
        checkOutput("3x5_result", result, 15);
        checkOutput("3x5_overflow", overflow, 0);
        // Backpressure: response held, new requests refused.
        req_valid = 1'b1;
        repeat (5) begin
            @(posedge clk); #1;
            checkOutput("bp_valid", resp_valid, 1);
            checkOutput("bp_result", result, 15);
            checkOutput("bp_req_ready", req_ready, 0);
        end
        req_valid = 1'b0;
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        checkOutput("bp_back_idle", req_ready, 1);

        applyStimulus(7, 0, 0);
        applyStimulus(0, 6, 0);
        applyStimulus(16, 16, 0);
        applyStimulus(255, 1, 0);
        applyStimulus(200, 2, 1);
        applyStimulus(255, 255, 0);

        // Abort during the first SHR of 3x5.
        a = 8'd3; b = 8'd5; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        checkOutput("abort_in_shr_op", alu_op, `SHIFT_RIGHT);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        checkOutput("abort_idle", req_ready, 1);
        begin
            int seen;
            seen = 0;
            repeat (12) begin
                if (resp_valid) seen++;
                @(posedge clk); #1;
            end
            checkOutput("abort_no_resp", seen, 0);
        end
        applyStimulus(4, 4, 0);

        // Asynchronous reset in the middle of an ADD cycle.
        a = 8'd3; b = 8'd5; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        checkOutput("arst_req_ready", req_ready, 1);
        checkOutput("arst_resp_valid", resp_valid, 0);
        checkOutput("arst_result", result, 0);
        checkOutput("arst_overflow", overflow, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        applyStimulus(3, 5, 0);

        for (int i = 0; i < 40; i++) begin
            int ra;
            int rb;
            ra = int'($urandom_range(0, 255));
            rb = (i % 4 == 0) ? int'($urandom_range(0, 7)) : int'($urandom_range(0, 255));
            applyStimulus(ra, rb, int'($urandom_range(0, 3)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

endmodule
